// File: rtl/bb_display_scan.sv
// Eight-digit multiplexed hex display driver for the 32-bit display bus.
// A loaded word is staged and committed only at a frame boundary, so one frame never shows two words.
module bb_display_scan #(
  parameter int                 DATAWIDTH_BUS     = 32,
  parameter int                 PRESCALER_MAX     = 50000,
  parameter int                 PRESCALER_WIDTH   = 16,
  parameter logic [DATAWIDTH_BUS-1:0] DATA_DISPLAY_INIT = 32'h00000000
) (
  input  logic                     BB_DISPLAY_SCAN_CLOCK_50,
  input  logic                     BB_DISPLAY_SCAN_Reset_InHigh,
  input  logic [DATAWIDTH_BUS-1:0] BB_DISPLAY_SCAN_DataBUS_In,
  input  logic                     BB_DISPLAY_SCAN_Load_InHigh,
  input  logic                     BB_DISPLAY_SCAN_Blank_InHigh,
  output logic [6:0]               BB_DISPLAY_SCAN_Seg_Out,
  output logic [7:0]               BB_DISPLAY_SCAN_Anode_Out,
  output logic                     BB_DISPLAY_SCAN_Frame_Out
);

  localparam logic [PRESCALER_WIDTH-1:0] PRE_LAST = PRESCALER_WIDTH'(PRESCALER_MAX - 1);

  logic [PRESCALER_WIDTH-1:0] prescaler_q, prescaler_d;
  logic [2:0]                 digit_idx_q, digit_idx_d;
  logic                       pending_q, pending_d;
  logic [DATAWIDTH_BUS-1:0]   staging_q, staging_d;
  logic [DATAWIDTH_BUS-1:0]   display_q, display_d;
  logic [6:0]                 seg_q, seg_d;
  logic [7:0]                 anode_q, anode_d;
  logic                       frame_q, frame_d;
  logic                       tick;
  logic                       frame_end;
  logic [3:0]                 nibble;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  always_comb begin
    tick        = (prescaler_q == PRE_LAST);
    frame_end   = tick && (digit_idx_q == 3'd7);
    prescaler_d = tick ? '0 : prescaler_q + 1'b1;
    digit_idx_d = tick ? digit_idx_q + 3'd1 : digit_idx_q;

    // Commit uses the word staged before this edge; a same-edge load re-arms pending.
    display_d = (frame_end && pending_q) ? staging_q : display_q;
    staging_d = BB_DISPLAY_SCAN_Load_InHigh ? BB_DISPLAY_SCAN_DataBUS_In : staging_q;
    pending_d = pending_q;
    if (BB_DISPLAY_SCAN_Load_InHigh) begin
      pending_d = 1'b1;
    end else if (frame_end) begin
      pending_d = 1'b0;
    end

    nibble  = display_q[{digit_idx_q, 2'b00} +: 4];
    seg_d   = BB_DISPLAY_SCAN_Blank_InHigh ? 7'h7F : hex_to_seg(nibble);
    anode_d = BB_DISPLAY_SCAN_Blank_InHigh ? 8'hFF : ~(8'b1 << digit_idx_q);
    frame_d = frame_end;
  end

  always_ff @(posedge BB_DISPLAY_SCAN_CLOCK_50) begin
    if (BB_DISPLAY_SCAN_Reset_InHigh) begin
      prescaler_q <= '0;
      digit_idx_q <= 3'd0;
      pending_q   <= 1'b0;
      staging_q   <= DATA_DISPLAY_INIT;
      display_q   <= DATA_DISPLAY_INIT;
      seg_q       <= 7'h7F;
      anode_q     <= 8'hFF;
      frame_q     <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      digit_idx_q <= digit_idx_d;
      pending_q   <= pending_d;
      staging_q   <= staging_d;
      display_q   <= display_d;
      seg_q       <= seg_d;
      anode_q     <= anode_d;
      frame_q     <= frame_d;
    end
  end

  assign BB_DISPLAY_SCAN_Seg_Out   = seg_q;
  assign BB_DISPLAY_SCAN_Anode_Out = anode_q;
  assign BB_DISPLAY_SCAN_Frame_Out = frame_q;

endmodule
